seg_scan_decoder: RTL and testbench

//  Receiving end of the 8-digit multiplexed 7-segment scan bus driven by the clock display driver.

---
 rtl/seg_scan_decoder_pkg.sv | 31 +++
 rtl/seg_scan_decoder_if.sv | 22 ++
 rtl/seg_scan_decoder_seg7.sv | 37 +++
 rtl/seg_scan_decoder.sv | 172 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan-bus decoder: segment patterns, digit codes, FSM states.
// Used by seg7_to_code and seg_scan_decoder (optional STABLE_CHECK_EN mask lives here too).
package seg_scan_pkg;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_DASH  = 8'h02;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hB;
    localparam logic [3:0] CODE_BAD   = 4'hF;

    localparam logic [31:0] DIGITS_RST  = 32'hBBBB_BBBB;
    // Slots 2 and 5 are the blinking separators and take no part in the stability compare.
    localparam logic [31:0] STABLE_MASK = 32'hFF0F_F0FF;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Scan-bus bundle between the display driver side (master) and the decoder (slave).
interface seg_scan_decoder_if #(
    parameter int FRAME_CNT_W = 8
);
    logic [2:0]             sel_in;
    logic [7:0]             seg_in;
    logic [31:0]            digits_out;
    logic                   frame_valid;
    logic                   frame_bad;
    logic                   seq_err;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    modport master (
        output sel_in, seg_in,
        input  digits_out, frame_valid, frame_bad, seq_err, frame_cnt
    );

    modport slave (
        input  sel_in, seg_in,
        output digits_out, frame_valid, frame_bad, seq_err, frame_cnt
    );
endinterface

// File: rtl/seg_scan_decoder_seg7.sv
// seg7_to_code: combinational segment byte -> 4-bit digit code (0-9, A dash, B blank, F undecodable).
module seg7_to_code
    import seg_scan_pkg::*;
#(
    parameter int SEG_ACT_HIGH = 1
) (
    input  logic [7:0] i_seg,
    output logic [3:0] o_code
);
    logic [7:0] w_seg;

    assign w_seg = (SEG_ACT_HIGH != 0) ? i_seg : ~i_seg;

    // Digits ignore dp; dash and blank must match the whole byte.
    always_comb begin
        o_code = CODE_BAD;
        if (w_seg == SEG_DASH) begin
            o_code = CODE_DASH;
        end else if (w_seg == SEG_BLANK) begin
            o_code = CODE_BLANK;
        end else begin
            case (w_seg[7:1])
                SEG_0[7:1]: o_code = 4'h0;
                SEG_1[7:1]: o_code = 4'h1;
                SEG_2[7:1]: o_code = 4'h2;
                SEG_3[7:1]: o_code = 4'h3;
                SEG_4[7:1]: o_code = 4'h4;
                SEG_5[7:1]: o_code = 4'h5;
                SEG_6[7:1]: o_code = 4'h6;
                SEG_7[7:1]: o_code = 4'h7;
                SEG_8[7:1]: o_code = 4'h8;
                SEG_9[7:1]: o_code = 4'h9;
                default:    o_code = CODE_BAD;
            endcase
        end
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples the 8-slot scan bus, decodes slots and reassembles in-order frames.
// Optional macro STABLE_CHECK_EN: accept a frame only if its non-separator slots match the previous frame.
//
// state   | meaning
// HUNT    | waiting for slot 0 to start a frame
// COLLECT | storing slots in order, exp_idx is the next expected slot
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int SEG_ACT_HIGH = 1,
    parameter int FRAME_CNT_W  = 8
) (
    input  logic               CLK_1kHz,
    input  logic               reset,
    seg_scan_decoder_if.slave  bus
);
    logic                   r_smp_vld;
    logic [2:0]             r_sel_q;
    logic [7:0]             r_seg_q;
    logic [3:0]             w_code;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [2:0]             r_exp_idx;
    logic [2:0]             w_exp_nxt;
    logic                   w_store;
    logic                   w_mismatch;
    logic                   w_last;

    logic [31:0]            r_slots;
    logic                   r_done;
    logic                   r_seq_pend;
    logic                   w_slots_bad;
    logic                   w_accept;

    logic [31:0]            r_digits;
    logic                   r_fv;
    logic                   r_bad;
    logic                   r_se;
    logic [FRAME_CNT_W-1:0] r_cnt;

    seg7_to_code #(.SEG_ACT_HIGH(SEG_ACT_HIGH)) u_dec (
        .i_seg  (r_seg_q),
        .o_code (w_code)
    );

    always_ff @(posedge CLK_1kHz or negedge reset) begin
        if (!reset) begin
            r_smp_vld <= 1'b0;
            r_sel_q   <= 3'd0;
            r_seg_q   <= 8'h00;
        end else begin
            r_smp_vld <= 1'b1;
            r_sel_q   <= bus.sel_in;
            r_seg_q   <= bus.seg_in;
        end
    end

    always_ff @(posedge CLK_1kHz or negedge reset) begin
        if (!reset) begin
            r_state   <= HUNT;
            r_exp_idx <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_exp_idx <= w_exp_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp_idx;
        if (r_smp_vld) begin
            case (r_state)
                HUNT: begin
                    if (r_sel_q == 3'd0) begin
                        w_state_nxt = COLLECT;
                        w_exp_nxt   = 3'd1;
                    end
                end
                COLLECT: begin
                    if (r_sel_q == r_exp_idx) begin
                        w_exp_nxt = r_exp_idx + 3'd1;
                    end else if (r_sel_q == 3'd0) begin
                        w_exp_nxt = 3'd1;
                    end else begin
                        w_state_nxt = HUNT;
                        w_exp_nxt   = 3'd0;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_exp_nxt   = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_store    = 1'b0;
        w_mismatch = 1'b0;
        w_last     = 1'b0;
        if (r_smp_vld) begin
            if (r_state == HUNT) begin
                w_store = (r_sel_q == 3'd0);
            end else begin
                w_mismatch = (r_sel_q != r_exp_idx);
                w_store    = !w_mismatch || (r_sel_q == 3'd0);
                w_last     = !w_mismatch && (r_exp_idx == 3'd7);
            end
        end
    end

    always_comb begin
        w_slots_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_slots_bad = w_slots_bad | (r_slots[4*i +: 4] == CODE_BAD);
        end
    end

`ifdef STABLE_CHECK_EN
    logic [31:0] r_ref;
    logic        r_ref_vld;

    always_ff @(posedge CLK_1kHz or negedge reset) begin
        if (!reset) begin
            r_ref     <= DIGITS_RST;
            r_ref_vld <= 1'b0;
        end else if (r_done) begin
            r_ref     <= r_slots;
            r_ref_vld <= 1'b1;
        end
    end

    assign w_accept = r_done && r_ref_vld &&
                      ((r_slots & STABLE_MASK) == (r_ref & STABLE_MASK));
`else
    assign w_accept = r_done;
`endif

    always_ff @(posedge CLK_1kHz or negedge reset) begin
        if (!reset) begin
            r_slots    <= DIGITS_RST;
            r_done     <= 1'b0;
            r_seq_pend <= 1'b0;
            r_digits   <= DIGITS_RST;
            r_fv       <= 1'b0;
            r_bad      <= 1'b0;
            r_se       <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_store) begin
                r_slots[{r_sel_q, 2'b00} +: 4] <= w_code;
            end
            r_done     <= w_last;
            // A break right after slot 7 would collide with frame_valid; push seq_err one cycle later.
            r_se       <= (w_mismatch && !r_done) || r_seq_pend;
            r_seq_pend <= w_mismatch && r_done;
            r_fv       <= w_accept;
            r_bad      <= w_accept && w_slots_bad;
            if (w_accept) begin
                r_digits <= r_slots;
                r_cnt    <= r_cnt + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.digits_out  = r_digits;
    assign bus.frame_valid = r_fv;
    assign bus.frame_bad   = r_bad;
    assign bus.seq_err     = r_se;
    assign bus.frame_cnt   = r_cnt;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (default build): frame vectors from a table plus reset/ordering sequences.
module tb_seg_scan_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_decoder_if #(.FRAME_CNT_W(8)) bus();

    seg_scan_decoder #(.SEG_ACT_HIGH(1), .FRAME_CNT_W(8)) dut (
        .CLK_1kHz (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [63:0] segs;
        logic [31:0] exp_digits;
        logic        exp_bad;
    } vec_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_fv = 0;
    int          n_se = 0;
    int          n_both = 0;
    int          exp_cnt = 0;
    logic [31:0] last_digits = '0;
    logic        last_bad = 1'b0;
    time         last_fv_t = 0;
    time         t_slot7 = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_valid) begin
                n_fv        = n_fv + 1;
                last_digits = bus.digits_out;
                last_bad    = bus.frame_bad;
                last_fv_t   = $time;
            end
            if (bus.seq_err) n_se = n_se + 1;
            if (bus.frame_valid && bus.seq_err) n_both = n_both + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] sel, input logic [7:0] seg);
        @(negedge clk);
        bus.sel_in = sel;
        bus.seg_in = seg;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(3'd3, 8'h00);
        #1;
    endtask

    task automatic send_frame(input logic [63:0] segs);
        for (int i = 0; i < 8; i++) send(3'(i), segs[8*i +: 8]);
        t_slot7 = $time;
    endtask

    vec_t vecs[5];
    int   fv0, se0;

    localparam logic [63:0] F_1234 = {8'hBE, 8'hB6, 8'h02, 8'h66, 8'hF2, 8'h02, 8'hDA, 8'h60};
    localparam logic [63:0] F_1234B = {8'hBE, 8'hB6, 8'h00, 8'h66, 8'hF2, 8'h00, 8'hDA, 8'h60};
    localparam logic [63:0] F_DP = {8'hE1, 8'hBF, 8'hB7, 8'h67, 8'hF3, 8'hDB, 8'h61, 8'hFD};

    initial begin
        vecs[0] = '{F_1234, 32'h65A43A21, 1'b0};
        vecs[1] = '{{8'h00, 8'hF6, 8'hFE, 8'hE0, 8'h55, 8'h00, 8'h60, 8'hFC}, 32'hB987FB10, 1'b1};
        vecs[2] = '{F_DP, 32'h76543210, 1'b0};
        vecs[3] = '{{8'h7F, 8'h80, 8'hF7, 8'hFF, 8'h00, 8'h02, 8'h01, 8'h03}, 32'hFF98BAFF, 1'b1};
        vecs[4] = '{{8'hF2, 8'h66, 8'h02, 8'hB6, 8'hBE, 8'h02, 8'hF6, 8'hFE}, 32'h34A56A98, 1'b0};

        bus.sel_in = 3'd3;
        bus.seg_in = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_digits", bus.digits_out, 32'hBBBB_BBBB);
        chk("rst_fv", {31'd0, bus.frame_valid}, 32'd0);
        chk("rst_bad", {31'd0, bus.frame_bad}, 32'd0);
        chk("rst_seq_err", {31'd0, bus.seq_err}, 32'd0);
        chk("rst_cnt", {24'd0, bus.frame_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        for (int v = 0; v < 5; v++) begin
            fv0 = n_fv;
            se0 = n_se;
            send_frame(vecs[v].segs);
            idle(5);
            exp_cnt = exp_cnt + 1;
            chk($sformatf("v%0d_fv_pulses", v), 32'(n_fv - fv0), 32'd1);
            chk($sformatf("v%0d_digits", v), last_digits, vecs[v].exp_digits);
            chk($sformatf("v%0d_bad", v), {31'd0, last_bad}, {31'd0, vecs[v].exp_bad});
            chk($sformatf("v%0d_latency", v), 32'(last_fv_t - t_slot7), 32'd30);
            chk($sformatf("v%0d_seq_err", v), 32'(n_se - se0), 32'd1);
            chk($sformatf("v%0d_cnt", v), {24'd0, bus.frame_cnt}, 32'(exp_cnt));
            chk($sformatf("v%0d_hold", v), bus.digits_out, vecs[v].exp_digits);
        end

        // back-to-back frames with blinking separators
        fv0 = n_fv;
        se0 = n_se;
        send_frame(F_1234);
        send_frame(F_1234B);
        send_frame(F_1234);
        idle(5);
        exp_cnt = exp_cnt + 3;
        chk("b2b_fv_pulses", 32'(n_fv - fv0), 32'd3);
        chk("b2b_seq_err", 32'(n_se - se0), 32'd1);
        chk("b2b_cnt", {24'd0, bus.frame_cnt}, 32'(exp_cnt));
        chk("b2b_digits", last_digits, 32'h65A43A21);

        // out-of-order slot aborts the frame
        fv0 = n_fv;
        se0 = n_se;
        send(3'd0, 8'h60);
        send(3'd1, 8'h60);
        send(3'd2, 8'h60);
        send(3'd4, 8'h60);
        idle(5);
        chk("ooo_fv", 32'(n_fv - fv0), 32'd0);
        chk("ooo_seq_err", 32'(n_se - se0), 32'd1);
        send_frame(F_DP);
        idle(5);
        exp_cnt = exp_cnt + 1;
        chk("ooo_then_fv", 32'(n_fv - fv0), 32'd1);
        chk("ooo_then_digits", last_digits, 32'h76543210);
        chk("ooo_then_seq_err", 32'(n_se - se0), 32'd2);

        // stalled driver: repeated sel counts as a break
        se0 = n_se;
        fv0 = n_fv;
        send(3'd0, 8'hFC);
        send(3'd1, 8'hFC);
        send(3'd1, 8'hFC);
        idle(5);
        chk("stall_seq_err", 32'(n_se - se0), 32'd1);
        chk("stall_fv", 32'(n_fv - fv0), 32'd0);

        // reset in the middle of a frame
        for (int i = 0; i < 6; i++) send(3'(i), 8'h66);
        @(negedge clk);
        rst_n = 1'b0;
        exp_cnt = 0;
        #1;
        chk("mid_rst_digits", bus.digits_out, 32'hBBBB_BBBB);
        chk("mid_rst_cnt", {24'd0, bus.frame_cnt}, 32'd0);
        chk("mid_rst_fv", {31'd0, bus.frame_valid}, 32'd0);
        chk("mid_rst_seq_err", {31'd0, bus.seq_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // stream resumes at slot 3: ignored silently until slot 0
        fv0 = n_fv;
        se0 = n_se;
        for (int i = 3; i < 8; i++) send(3'(i), 8'h66);
        idle(5);
        chk("late_start_fv", 32'(n_fv - fv0), 32'd0);
        chk("late_start_seq_err", 32'(n_se - se0), 32'd0);
        chk("late_start_digits", bus.digits_out, 32'hBBBB_BBBB);
        send_frame(F_1234);
        idle(5);
        exp_cnt = exp_cnt + 1;
        chk("after_rst_fv", 32'(n_fv - fv0), 32'd1);
        chk("after_rst_digits", last_digits, 32'h65A43A21);
        chk("after_rst_cnt", {24'd0, bus.frame_cnt}, 32'(exp_cnt));

        chk("fv_seq_err_overlap", 32'(n_both), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
